// File: rtl/clock_enable_gen.sv
// Purpose: CHANNELS fractional clock-enable streams at clock*mul/div; optional ne phase under CLOCK_NE_EN.
// Latency: pe/ne registered, decided from current acc; first pe of mul=1/div=8 on 8th edge after ready.
// Backpressure: none; loads accepted every cycle, bad loads flagged by a one-cycle err pulse.
module clock_enable_gen #(
    parameter int CHANNELS = 2,
    parameter int MW       = 8,
    parameter int MUL_INIT = 1,
    parameter int DIV_INIT = 8,
    parameter int SETTLE   = 16,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [CH_W-1:0]     ch,
    input  logic [MW-1:0]       mul,
    input  logic [MW-1:0]       div,
    output logic                err,
    output logic                ready,
    output logic [CHANNELS-1:0] pe,
    output logic [CHANNELS-1:0] ne
);

    typedef struct packed {
        logic [MW-1:0] mul;
        logic [MW-1:0] div;
    } ratio_t;

    logic [7:0] settle_q;
    logic       load_ok;

    // mul<=div together with acc<div keeps acc+mul within MW+1 bits
    assign load_ok = load && (32'(ch) < 32'(CHANNELS)) && (div != '0) && (mul <= div);

    always_ff @(posedge clock) begin
        if (!reset) begin
            settle_q <= '0;
            ready    <= 1'b0;
            err      <= 1'b0;
        end else begin
            err <= load && !load_ok;
            if (!ready) begin
                settle_q <= settle_q + 8'd1;
                if (settle_q + 8'd1 == 8'(SETTLE))
                    ready <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        ratio_t        ratio_q;
        logic [MW-1:0] acc_q;
        logic [MW:0]   sum;
        logic          wrap;
        logic          hit;
        logic          pe_q;

        assign hit  = load_ok && (ch == CH_W'(g));
        assign sum  = {1'b0, acc_q} + {1'b0, ratio_q.mul};
        assign wrap = sum >= {1'b0, ratio_q.div};
        assign pe[g] = pe_q;

`ifdef CLOCK_NE_EN
        logic [MW-1:0] half;
        logic          cross;
        logic          ne_q;

        // half-point crossing without wrap puts ne roughly mid-way between pe pulses
        assign half  = ratio_q.div >> 1;
        assign cross = !wrap && (acc_q < half) && (sum >= {1'b0, half});
        assign ne[g] = ne_q;

        always_ff @(posedge clock) begin
            if (!reset)
                ne_q <= 1'b0;
            else if (hit || !ready)
                ne_q <= 1'b0;
            else
                ne_q <= cross;
        end
`endif

        always_ff @(posedge clock) begin
            if (!reset) begin
                ratio_q <= {MW'(MUL_INIT), MW'(DIV_INIT)};
                acc_q   <= '0;
                pe_q    <= 1'b0;
            end else if (hit) begin
                // a load beats a coincident wrap: pulse suppressed, phase restarts
                ratio_q <= {mul, div};
                acc_q   <= '0;
                pe_q    <= 1'b0;
            end else if (!ready) begin
                acc_q <= '0;
                pe_q  <= 1'b0;
            end else begin
                acc_q <= wrap ? MW'(sum - {1'b0, ratio_q.div}) : sum[MW-1:0];
                pe_q  <= wrap;
            end
        end
    end

`ifndef CLOCK_NE_EN
    assign ne = '0;
`endif

endmodule

// File: tb/tb_clock_enable_gen.sv
// Directed bench for clock_enable_gen: settle, ratio trains, loads, rejects, mid-train reset.
// Three channels so that a 2-bit ch can address a non-existent channel (ch=3).
module tb_clock_enable_gen;

    localparam int CHN = 3;

    logic           clock;
    logic           reset;
    logic           load;
    logic [1:0]     ch;
    logic [7:0]     mul;
    logic [7:0]     div;
    logic           err;
    logic           ready;
    logic [CHN-1:0] pe;
    logic [CHN-1:0] ne;

    int n_cmp = 0;
    int n_bad = 0;

    // ch0 phase tracker: ph==0 is the pe cycle of its fixed 1/8 train
    bit ch0_on = 0;
    int ph = 0;
    int ch0_bad = 0;
    int coinc_bad = 0;
    int ne_bad = 0;

    clock_enable_gen #(.CHANNELS(CHN)) dut (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .ch    (ch),
        .mul   (mul),
        .div   (div),
        .err   (err),
        .ready (ready),
        .pe    (pe),
        .ne    (ne)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if ((pe & ne) != '0) coinc_bad++;
`ifndef CLOCK_NE_EN
        if (ne !== '0) ne_bad++;
`endif
        if (ch0_on) begin
            ph = (ph + 1) % 8;
            if (pe[0] !== (ph == 0)) ch0_bad++;
`ifdef CLOCK_NE_EN
            if (ne[0] !== (ph == 4)) ch0_bad++;
`endif
        end
    endtask

    task automatic do_load(input logic [1:0] c, input logic [7:0] m, input logic [7:0] d);
        load = 1'b1;
        ch   = c;
        mul  = m;
        div  = d;
        tick();
        load = 1'b0;
    endtask

    logic [1:0] rej_ch  [3] = '{2'd1, 2'd1, 2'd3};
    logic [7:0] rej_mul [3] = '{8'd5, 8'd1, 8'd1};
    logic [7:0] rej_div [3] = '{8'd4, 8'd0, 8'd2};

    initial begin
        int n;
        int bad;
        int cnt;
        int cnt2;
        int last;
        int first;

        reset = 1'b0;
        load  = 1'b0;
        ch    = '0;
        mul   = '0;
        div   = '0;

        // reset held 5 cycles
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (pe !== '0 || ne !== '0 || err !== 1'b0 || ready !== 1'b0) bad++;
        end
        chk("reset_outs", bad, 0);
        chk("reset_ready", ready, 0);

        reset = 1'b1;
        n = 0;
        bad = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
            if (pe !== '0 || err !== 1'b0) bad++;
        end
        chk("settle_len", n, 16);
        chk("settle_quiet", bad, 0);

        // first pulse of the 1/8 reset ratio
        n = 0;
        do begin
            tick();
            n++;
        end while (pe[0] !== 1'b1 && n < 20);
        chk("first_pe0", n, 8);
        chk("first_pe1", pe[1], 1);
        ph = 0;
        ch0_on = 1;
        repeat (24) tick();
        chk("ch0_period", ch0_bad, 0);

        // load ch1 3/8 exactly on the cycle its 1/8 wrap would pulse
        while (ph != 7) tick();
        do_load(2'd1, 8'd3, 8'd8);
        chk("ld_wrap_suppress", pe[1], 0);
        chk("ld_ok_err", err, 0);
        cnt = 0;
        last = 0;
        first = 0;
        bad = 0;
        for (int i = 1; i <= 800; i++) begin
            tick();
            if (pe[1]) begin
                cnt++;
                if (first == 0) first = i;
                if (last != 0 && (i - last < 2 || i - last > 3)) bad++;
                last = i;
            end
        end
        chk("ch1_first", first, 3);
        chk("ch1_count800", cnt, 300);
        chk("ch1_gaps", bad, 0);
        chk("ch0_across_load", ch0_bad, 0);

        // rejected loads
        for (int k = 0; k < 3; k++) begin
            do_load(rej_ch[k], rej_mul[k], rej_div[k]);
            chk($sformatf("rej_err_%0d", k), err, 1);
            tick();
            chk($sformatf("rej_err_clr_%0d", k), err, 0);
        end
        cnt = 0;
        cnt2 = 0;
        repeat (80) begin
            tick();
            if (pe[1]) cnt++;
            if (pe[2]) cnt2++;
        end
        chk("rej_ch1_rate", cnt, 30);
        chk("rej_ch2_rate", cnt2, 10);
        chk("ch0_after_rej", ch0_bad, 0);

        // mul==div: every cycle, ne never
        do_load(2'd1, 8'd8, 8'd8);
        chk("full_ld_pe", pe[1], 0);
        cnt = 0;
        cnt2 = 0;
        repeat (20) begin
            tick();
            if (pe[1]) cnt++;
            if (ne[1]) cnt2++;
        end
        chk("full_pe_cnt", cnt, 20);
        chk("full_ne_cnt", cnt2, 0);

        // mul==0: stopped
        do_load(2'd1, 8'd0, 8'd8);
        cnt = 0;
        cnt2 = 0;
        repeat (100) begin
            tick();
            if (pe[1]) cnt++;
            if (ne[1]) cnt2++;
        end
        chk("stop_pe_cnt", cnt, 0);
        chk("stop_ne_cnt", cnt2, 0);
        chk("ch0_after_stop", ch0_bad, 0);

        // reset mid-train on a pe cycle, with a valid load pending that must be dropped
        n = 0;
        while (ph != 0 && n < 8) begin
            tick();
            n++;
        end
        chk("pre_rst_pe0", pe[0], 1);
        ch0_on = 0;
        reset = 1'b0;
        do_load(2'd1, 8'd3, 8'd8);
        chk("rst_pe_drop", pe, 0);
        chk("rst_ready_drop", ready, 0);
        chk("rst_err", err, 0);
        repeat (2) tick();
        reset = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("resettle_len", n, 16);
        n = 0;
        do begin
            tick();
            n++;
        end while (pe[1] !== 1'b1 && n < 20);
        chk("rst_ch1_default", n, 8);
        chk("rst_ch0_default", pe[0], 1);

        chk("pe_ne_coincident", coinc_bad, 0);
        chk("ne_tied_low", ne_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
